// File: rtl/alu_mul_sequencer.sv
// alu_mul_sequencer: iterative shift-add low-word multiplier that borrows the
// shared single-cycle ALU for its partial-product additions, one per clock.
//
//   state | meaning
//   IDLE  | waiting for start; operands captured when start is sampled
//   RUN   | one multiplier bit consumed per cycle, ALU adds mcand or 0 to acc
//   DONE  | product valid, done pulses for this single cycle
module alu_mul_sequencer #(
  parameter int         WIDTH    = 32,
  parameter logic [3:0] CTRL_ADD = 4'b0010
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product,
  output logic [WIDTH-1:0] alu_src_a,
  output logic [WIDTH-1:0] alu_src_b,
  output logic [3:0]       alu_control,
  input  logic [WIDTH-1:0] alu_result
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;

  // Sequencer state, working registers and the held product.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      product <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            acc     <= '0;
            mcand   <= op_a;
            mplier  <= op_b;
            product <= '0;
            // A zero multiplier has nothing to add; the cleared product is the answer.
            state   <= (op_b == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          acc    <= alu_result;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          // Stop once no set multiplier bits remain above the one consumed now.
          if (mplier[WIDTH-1:1] == '0) begin
            product <= alu_result;
            state   <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Handshake flags are plain decodes of the registered state.
  assign busy = (state != IDLE);
  assign done = (state == DONE);

  // The ALU always adds; the operand gate selects between mcand and zero.
  assign alu_control = CTRL_ADD;
  assign alu_src_a   = acc;
  assign alu_src_b   = ((state == RUN) && mplier[0]) ? mcand : '0;

endmodule
